// File: rtl/seq_scan_scheduler.sv
// Round-robin scheduler that shares one serial, overlapping pattern matcher among NCH channels.
// Each channel keeps its own bit history, so a match can span two consecutive words of that channel.
module seq_scan_scheduler #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned PLEN = 6,
    parameter logic [PLEN-1:0] PATTERN = 6'b100111,
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned PW = (DW > 1) ? $clog2(DW) : 1,
    localparam int unsigned KW = $clog2(DW + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*DW-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH-1:0]    hist_clr,
    output logic              busy,
    output logic              det_valid,
    output logic [CW-1:0]     det_chan,
    output logic [PW-1:0]     det_pos,
    output logic              done_valid,
    output logic [CW-1:0]     done_chan,
    output logic [KW-1:0]     done_count
);

    localparam int unsigned FW = $clog2(PLEN);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [CW-1:0]   last_grant;
    logic [CW-1:0]   cur_chan;
    logic [CW-1:0]   grant_idx;
    logic [CW-1:0]   cand;
    logic            grant_any;
    logic            accept;
    logic [DW-1:0]   grant_word;
    logic [DW-1:0]   word;
    logic [PW-1:0]   bit_idx;
    logic [KW-1:0]   match_count;
    logic [PLEN-2:0] hist [NCH];
    logic [FW-1:0]   fill [NCH];
    logic [PLEN-1:0] window;
    logic            match;

    // Current word is consumed MSB-first by shifting it left each SHIFT cycle.
    assign window = {hist[cur_chan], word[DW-1]};
    assign match  = (state == SHIFT) && (window == PATTERN)
                    && (fill[cur_chan] == FW'(PLEN - 1));
    assign busy   = (state != IDLE);

    // Round-robin grant, handshake and next-state decode.
    always_comb begin
        state_next = state;
        grant_any  = 1'b0;
        grant_idx  = last_grant;
        cand       = last_grant;
        grant_word = '0;
        req_ready  = '0;
        accept     = 1'b0;

        for (int i = 1; i <= int'(NCH); i++) begin
            cand = CW'((int'(last_grant) + i) % int'(NCH));
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end

        for (int i = 0; i < int'(NCH); i++) begin
            if (CW'(i) == grant_idx) begin
                grant_word = req_data[i*DW +: DW];
            end
        end

        case (state)
            IDLE: begin
                if (!reset && enable && grant_any) begin
                    accept               = 1'b1;
                    req_ready[grant_idx] = 1'b1;
                    state_next           = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_idx == PW'(DW - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word datapath, match reporting and per-channel history.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= CW'(NCH - 1);
            cur_chan    <= '0;
            word        <= '0;
            bit_idx     <= '0;
            match_count <= '0;
            det_valid   <= 1'b0;
            det_chan    <= '0;
            det_pos     <= '0;
            done_valid  <= 1'b0;
            done_chan   <= '0;
            done_count  <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
        end else begin
            det_valid  <= 1'b0;
            done_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        word        <= grant_word;
                        cur_chan    <= grant_idx;
                        last_grant  <= grant_idx;
                        bit_idx     <= '0;
                        match_count <= '0;
                    end
                end
                SHIFT: begin
                    word    <= word << 1;
                    bit_idx <= bit_idx + PW'(1);
                    if (match) begin
                        det_valid   <= 1'b1;
                        det_chan    <= cur_chan;
                        det_pos     <= bit_idx;
                        match_count <= match_count + KW'(1);
                    end
                end
                DONE: begin
                    done_valid <= 1'b1;
                    done_chan  <= cur_chan;
                    done_count <= match_count;
                end
                default: begin
                end
            endcase

            // A clear wins over the active channel's shift; the compare above still used the old window.
            for (int i = 0; i < int'(NCH); i++) begin
                if (hist_clr[i]) begin
                    hist[i] <= '0;
                    fill[i] <= '0;
                end else if (state == SHIFT && CW'(i) == cur_chan) begin
                    hist[i] <= window[PLEN-2:0];
                    if (fill[i] != FW'(PLEN - 1)) begin
                        fill[i] <= fill[i] + FW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_scheduler.sv
// Directed bench for seq_scan_scheduler: a vector table of words per channel plus
// hand-written sequences for reset, enable gating, round robin and fill gating.
module tb_seq_scan_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 2;
    localparam int PW  = 3;
    localparam int KW  = 4;

    typedef struct {
        int         ch;
        logic [7:0] data;
        bit         clr;
        logic [7:0] exp_mask;
        int         exp_cnt;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH*DW-1:0] req_data = '0;
    logic [NCH-1:0]    hist_clr = '0;

    logic [NCH-1:0] req_ready,  zreq_ready;
    logic           busy,       zbusy;
    logic           det_valid,  zdet_valid;
    logic [CW-1:0]  det_chan,   zdet_chan;
    logic [PW-1:0]  det_pos,    zdet_pos;
    logic           done_valid, zdone_valid;
    logic [CW-1:0]  done_chan,  zdone_chan;
    logic [KW-1:0]  done_count, zdone_count;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    seq_scan_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .hist_clr(hist_clr), .busy(busy),
        .det_valid(det_valid), .det_chan(det_chan), .det_pos(det_pos),
        .done_valid(done_valid), .done_chan(done_chan), .done_count(done_count)
    );

    seq_scan_scheduler #(.PATTERN(6'b000000)) dut_zero (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(zreq_ready),
        .hist_clr(hist_clr), .busy(zbusy),
        .det_valid(zdet_valid), .det_chan(zdet_chan), .det_pos(zdet_pos),
        .done_valid(zdone_valid), .done_chan(zdone_chan), .done_count(zdone_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        hist_clr  = '0;
        enable    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one word on channel ch, then collect detections until done (call in the low clock phase).
    task automatic run_word(input int ch, input logic [7:0] data,
                            output logic [7:0] mask, output int cnt, output int dchan,
                            output logic [7:0] zmask, output int zcnt,
                            output int acc, output int waits);
        bit got;
        mask  = '0;
        zmask = '0;
        cnt   = -1;
        zcnt  = -1;
        dchan = -1;
        acc   = -1;
        waits = 0;
        got   = 1'b0;
        req_valid = NCH'(1) << ch;
        req_data[ch*DW +: DW] = data;
        #1;
        while (req_ready[ch] !== 1'b1 && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (req_ready[ch] !== 1'b1) begin
            check("grant_timeout", 0, 1);
            req_valid = '0;
            return;
        end
        check("zero_inst_ready", int'(zreq_ready[ch]), 1);
        acc = cyc;
        @(negedge clk);
        req_valid = '0;
        for (int n = 0; n < DW + 6 && !got; n++) begin
            #1;
            if (det_valid) begin
                mask[det_pos] = 1'b1;
                check("det_chan", int'(det_chan), ch);
            end
            if (zdet_valid) begin
                zmask[zdet_pos] = 1'b1;
                check("zero_det_chan", int'(zdet_chan), ch);
            end
            if (zdone_valid) begin
                zcnt = int'(zdone_count);
                check("zero_done_chan", int'(zdone_chan), ch);
            end
            if (done_valid) begin
                cnt   = int'(done_count);
                dchan = int'(done_chan);
                got   = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    initial begin
        vec_t       vecs [8];
        logic [7:0] m, zm;
        int         c, zc, dc, acc, w, prev_acc;
        int         ds, rs, dcyc, ng;
        int         order [6];
        int         gcyc [6];
        int         exp_rr [6];

        vecs[0] = '{0, 8'b10011100, 1'b0, 8'b0010_0000, 1};
        vecs[1] = '{1, 8'b00000100, 1'b0, 8'b0000_0000, 0};
        vecs[2] = '{1, 8'b11100000, 1'b0, 8'b0000_0100, 1};
        vecs[3] = '{0, 8'b00000100, 1'b0, 8'b0000_0000, 0};
        vecs[4] = '{0, 8'b11100000, 1'b1, 8'b0000_0000, 0};
        vecs[5] = '{2, 8'b00100111, 1'b0, 8'b1000_0000, 1};
        vecs[6] = '{3, 8'b00010011, 1'b0, 8'b0000_0000, 0};
        vecs[7] = '{3, 8'b10011100, 1'b0, 8'b0010_0001, 2};
        exp_rr  = '{0, 1, 2, 3, 0, 1};

        // Reset held with every channel requesting: nothing may be granted.
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_det_valid", int'(det_valid), 0);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_done_count", int'(done_count), 0);
        check("rst_zero_busy", int'(zbusy), 0);
        do_reset();

        // Fill gating on the all-zero pattern instance.
        run_word(3, 8'h00, m, c, dc, zm, zc, acc, w);
        check("fill_first_mask", int'(zm), 8'hE0);
        check("fill_first_cnt", zc, 3);
        check("fill_main_cnt", c, 0);
        check("fill_done_chan", dc, 3);
        run_word(3, 8'h00, m, c, dc, zm, zc, acc, w);
        check("fill_second_mask", int'(zm), 8'hFF);
        check("fill_second_cnt", zc, 8);

        // Vector table on the main instance.
        do_reset();
        prev_acc = 0;
        foreach (vecs[i]) begin
            if (vecs[i].clr) begin
                hist_clr[vecs[i].ch] = 1'b1;
                @(negedge clk);
                hist_clr = '0;
            end
            run_word(vecs[i].ch, vecs[i].data, m, c, dc, zm, zc, acc, w);
            check($sformatf("v%0d_mask", i), int'(m), int'(vecs[i].exp_mask));
            check($sformatf("v%0d_count", i), c, vecs[i].exp_cnt);
            check($sformatf("v%0d_done_chan", i), dc, vecs[i].ch);
            if (i == 0) check("v0_ready_first_cycle", w, 0);
            else if (!vecs[i].clr) check($sformatf("v%0d_spacing", i), acc - prev_acc, DW + 2);
            prev_acc = acc;
        end

        // Reset in the middle of a word that has already shifted bits 1,0,0 into ch1's history.
        req_valid = 4'b0010;
        req_data[15:8] = 8'b10000000;
        w = 0;
        #1;
        while (req_ready[1] !== 1'b1 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("mw_grant", int'(req_ready[1]), 1);
        acc = cyc;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req_valid = 4'b0010;
        @(negedge clk);
        #1;
        check("mw_cycle", cyc - acc, 5);
        check("mw_busy", int'(busy), 0);
        check("mw_ready_forced", int'(req_ready), 0);
        check("mw_det_valid", int'(det_valid), 0);
        check("mw_det_chan", int'(det_chan), 0);
        check("mw_det_pos", int'(det_pos), 0);
        check("mw_done_valid", int'(done_valid), 0);
        check("mw_done_chan", int'(done_chan), 0);
        check("mw_done_count", int'(done_count), 0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;
        run_word(1, 8'b11100000, m, c, dc, zm, zc, acc, w);
        check("stale_mask", int'(m), 0);
        check("stale_count", c, 0);

        // Enable dropped mid-word: the word finishes, nothing new is granted.
        req_valid = 4'b0100;
        req_data[23:16] = 8'h00;
        w = 0;
        #1;
        while (req_ready[2] !== 1'b1 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("en_grant", int'(req_ready[2]), 1);
        acc = cyc;
        @(negedge clk);
        enable = 1'b0;
        ds = 0;
        rs = 0;
        dcyc = -1;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (done_valid) begin
                ds++;
                dcyc = cyc;
            end
            if (req_ready != '0) rs++;
            @(negedge clk);
        end
        check("en_done_pulses", ds, 1);
        check("en_done_latency", dcyc - acc, DW + 2);
        check("en_no_ready", rs, 0);
        enable = 1'b1;
        #1;
        check("en_resume_ready", int'(req_ready), 4'b0100);
        req_valid = '0;
        repeat (12) @(negedge clk);

        // Round robin with all channels requesting continuously.
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = '1;
        ng = 0;
        for (int n = 0; n < 80 && ng < 6; n++) begin
            #1;
            if (req_ready != '0) begin
                check("rr_onehot", $countones(req_ready), 1);
                for (int j = 0; j < NCH; j++) begin
                    if (req_ready[j]) order[ng] = j;
                end
                gcyc[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        check("rr_grant_count", ng, 6);
        for (int i = 0; i < 6 && i < ng; i++) begin
            check($sformatf("rr_order%0d", i), order[i], exp_rr[i]);
            if (i > 0) check($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], DW + 2);
        end
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
